// File: rtl/phase_measure.sv
// Measures period, phase offset and high time of sig_in against ref_in, in clk cycles.
// Flags lock once LOCK_COUNT consecutive windows agree within TOL.
module phase_measure #(
  parameter int CNT_W      = 16,
  parameter int LOCK_COUNT = 4,
  parameter int TOL        = 1
) (
  input  logic             clk,
  input  logic             RST,
  input  logic             PWRDWN,
  input  logic             ref_in,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period_cnt,
  output logic [CNT_W-1:0] offset_cnt,
  output logic [CNT_W-1:0] high_cnt,
  output logic             valid,
  output logic             lock,
  output logic             err
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] TOL_W   = CNT_W'(TOL);
  localparam int               MW      = $clog2(LOCK_COUNT) + 1;
  localparam logic [MW-1:0]    LOCK_TH = MW'(LOCK_COUNT - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT_REF = 2'd1, MEAS = 2'd2} state_t;
  state_t state_reg, state_next;

  logic [2:0] ref_sync_reg, sig_sync_reg;
  logic       ref_rise, sig_rise, sig_fall;

  logic [CNT_W-1:0] elapsed_reg, elapsed_next;
  logic [CNT_W-1:0] win_off_reg, win_off_next;
  logic             seen_reg, seen_next;
  logic [CNT_W-1:0] high_ctr_reg, high_ctr_next;
  logic             high_run_reg, high_run_next;
  logic [CNT_W-1:0] high_last_reg, high_last_next, high_last_now;
  logic [CNT_W-1:0] period_next, offset_next, high_next;
  logic             valid_next, lock_next, err_next;
  logic [MW-1:0]    match_reg, match_next;
  logic             have_prev_reg, have_prev_next;
  logic             start_window;

  // Edges come from the second/third synchronizer stages so both inputs see equal latency
  assign ref_rise = ref_sync_reg[1] & ~ref_sync_reg[2];
  assign sig_rise = sig_sync_reg[1] & ~sig_sync_reg[2];
  assign sig_fall = ~sig_sync_reg[1] & sig_sync_reg[2];

  // A fall in the closing cycle already counts as the latest completed high pulse
  assign high_last_now = (sig_fall && high_run_reg) ? high_ctr_reg : high_last_reg;

  function automatic logic near(input logic [CNT_W-1:0] a, input logic [CNT_W-1:0] b);
    logic [CNT_W-1:0] d;
    d = (a > b) ? (a - b) : (b - a);
    return d <= TOL_W;
  endfunction

  always_comb begin
    state_next     = state_reg;
    elapsed_next   = elapsed_reg;
    win_off_next   = win_off_reg;
    seen_next      = seen_reg;
    high_ctr_next  = high_ctr_reg;
    high_run_next  = high_run_reg;
    high_last_next = high_last_now;
    period_next    = period_cnt;
    offset_next    = offset_cnt;
    high_next      = high_cnt;
    valid_next     = 1'b0;
    err_next       = 1'b0;
    lock_next      = lock;
    match_next     = match_reg;
    have_prev_next = have_prev_reg;
    start_window   = 1'b0;

    if (sig_rise) begin
      high_ctr_next = CNT_ONE;
      high_run_next = 1'b1;
    end else if (sig_fall) begin
      high_run_next = 1'b0;
    end else if (high_run_reg && high_ctr_reg != CNT_MAX) begin
      high_ctr_next = high_ctr_reg + CNT_ONE;
    end

    case (state_reg)
      IDLE: state_next = WAIT_REF;
      WAIT_REF: begin
        if (ref_rise) begin
          state_next   = MEAS;
          start_window = 1'b1;
        end
      end
      MEAS: begin
        if (ref_rise) begin
          start_window = 1'b1;
          if (seen_reg) begin
            valid_next  = 1'b1;
            period_next = elapsed_reg;
            offset_next = win_off_reg;
            high_next   = high_last_now;
            if (have_prev_reg && near(elapsed_reg, period_cnt) && near(win_off_reg, offset_cnt)) begin
              if (match_reg != LOCK_TH) match_next = match_reg + MW'(1);
            end else begin
              match_next = '0;
            end
            have_prev_next = 1'b1;
            lock_next      = (match_next >= LOCK_TH);
          end else begin
            err_next       = 1'b1;
            lock_next      = 1'b0;
            match_next     = '0;
            have_prev_next = 1'b0;
          end
        end else if (elapsed_reg == CNT_MAX) begin
          err_next       = 1'b1;
          lock_next      = 1'b0;
          match_next     = '0;
          have_prev_next = 1'b0;
          state_next     = WAIT_REF;
        end else begin
          elapsed_next = elapsed_reg + CNT_ONE;
          if (sig_rise && !seen_reg) begin
            win_off_next = elapsed_reg;
            seen_next    = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase

    if (start_window) begin
      elapsed_next = CNT_ONE;
      win_off_next = '0;
      seen_next    = sig_rise;
    end

    if (PWRDWN) begin
      state_next     = IDLE;
      elapsed_next   = '0;
      win_off_next   = '0;
      seen_next      = 1'b0;
      high_ctr_next  = '0;
      high_run_next  = 1'b0;
      high_last_next = '0;
      period_next    = '0;
      offset_next    = '0;
      high_next      = '0;
      valid_next     = 1'b0;
      err_next       = 1'b0;
      lock_next      = 1'b0;
      match_next     = '0;
      have_prev_next = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      ref_sync_reg  <= '0;
      sig_sync_reg  <= '0;
      elapsed_reg   <= '0;
      win_off_reg   <= '0;
      seen_reg      <= 1'b0;
      high_ctr_reg  <= '0;
      high_run_reg  <= 1'b0;
      high_last_reg <= '0;
      period_cnt    <= '0;
      offset_cnt    <= '0;
      high_cnt      <= '0;
      valid         <= 1'b0;
      lock          <= 1'b0;
      err           <= 1'b0;
      match_reg     <= '0;
      have_prev_reg <= 1'b0;
    end else begin
      ref_sync_reg  <= {ref_sync_reg[1:0], ref_in};
      sig_sync_reg  <= {sig_sync_reg[1:0], sig_in};
      elapsed_reg   <= elapsed_next;
      win_off_reg   <= win_off_next;
      seen_reg      <= seen_next;
      high_ctr_reg  <= high_ctr_next;
      high_run_reg  <= high_run_next;
      high_last_reg <= high_last_next;
      period_cnt    <= period_next;
      offset_cnt    <= offset_next;
      high_cnt      <= high_next;
      valid         <= valid_next;
      lock          <= lock_next;
      err           <= err_next;
      match_reg     <= match_next;
      have_prev_reg <= have_prev_next;
    end
  end

endmodule

// File: tb/tb_phase_measure.sv
// Bench for phase_measure: window-level reference model checked every cycle, plus
// literal expectations for the characteristic waveforms (CNT_W=8 so overflow is quick).
module tb_phase_measure;
  localparam int W    = 8;
  localparam int LC   = 4;
  localparam int TL   = 1;
  localparam int MAXV = 255;
  localparam int P    = 20;

  logic clk    = 1'b0;
  logic RST    = 1'b1;
  logic PWRDWN = 1'b0;
  logic ref_in = 1'b0;
  logic sig_in = 1'b0;
  logic [W-1:0] period_cnt, offset_cnt, high_cnt;
  logic valid, lock, err;

  int total = 0;
  int bad   = 0;

  // stimulus shape, changed by the main sequence
  int t = 0;
  bit ref_run = 1'b1;
  bit sig_run = 1'b1;
  int off = 5;
  int hi  = 10;

  always #5 clk = ~clk;

  phase_measure #(.CNT_W(W), .LOCK_COUNT(LC), .TOL(TL)) dut (
    .clk(clk), .RST(RST), .PWRDWN(PWRDWN), .ref_in(ref_in), .sig_in(sig_in),
    .period_cnt(period_cnt), .offset_cnt(offset_cnt), .high_cnt(high_cnt),
    .valid(valid), .lock(lock), .err(err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // waveform driver: ref is 50% duty, sig is a phase-shifted pulse of width hi
  initial begin : driver
    int ph;
    forever begin
      @(posedge clk);
      #1;
      ph = t % P;
      ref_in = ref_run ? (ph < 10) : 1'b0;
      sig_in = sig_run ? (((ph - off + P) % P) < hi) : 1'b0;
      t++;
    end
  end

  // ---------------- reference model ----------------
  // Events are indexed by the clock edge at which the input level was sampled; an
  // edge sampled at index j shows up on the outputs two edges later.
  int m_mode;             // 0 idle, 1 waiting for ref, 2 measuring
  int m_c0, m_fs, m_hrise, m_hlast, m_match;
  bit m_hrun, m_have_prev;
  bit [3:0] rh, sh;
  int e_period, e_offset, e_high;
  bit e_valid, e_lock, e_err;

  function automatic int iabs(input int x);
    return (x < 0) ? -x : x;
  endfunction

  task automatic model_clear();
    m_mode = 0; m_c0 = 0; m_fs = -1; m_hrise = 0; m_hlast = 0; m_match = 0;
    m_hrun = 1'b0; m_have_prev = 1'b0;
    e_period = 0; e_offset = 0; e_high = 0;
    e_valid = 1'b0; e_lock = 1'b0; e_err = 1'b0;
  endtask

  initial begin : model
    bit rr, sr, sf;
    int j, np, no;
    j = 0;
    rh = '0; sh = '0;
    model_clear();
    forever begin
      @(posedge clk);
      j++;
      if (RST) begin
        rh = '0; sh = '0;
        model_clear();
      end else begin
        rh = {rh[2:0], ref_in};
        sh = {sh[2:0], sig_in};
        rr = rh[2] & ~rh[3];
        sr = sh[2] & ~sh[3];
        sf = ~sh[2] & sh[3];
        e_valid = 1'b0;
        e_err   = 1'b0;
        if (PWRDWN) begin
          model_clear();
        end else begin
          if (sf && m_hrun) begin
            m_hlast = (j - m_hrise > MAXV) ? MAXV : (j - m_hrise);
            m_hrun  = 1'b0;
          end
          if (sr) begin
            m_hrise = j;
            m_hrun  = 1'b1;
          end
          if (m_mode == 0) begin
            m_mode = 1;
          end else if (m_mode == 1) begin
            if (rr) begin
              m_mode = 2; m_c0 = j; m_fs = sr ? j : -1;
            end
          end else begin
            if (rr) begin
              if (m_fs >= 0) begin
                np = j - m_c0;
                no = m_fs - m_c0;
                if (m_have_prev && iabs(np - e_period) <= TL && iabs(no - e_offset) <= TL)
                  m_match = (m_match < LC - 1) ? m_match + 1 : m_match;
                else
                  m_match = 0;
                m_have_prev = 1'b1;
                e_lock   = (m_match >= LC - 1);
                e_valid  = 1'b1;
                e_period = np;
                e_offset = no;
                e_high   = m_hlast;
              end else begin
                e_err = 1'b1; e_lock = 1'b0; m_match = 0; m_have_prev = 1'b0;
              end
              m_c0 = j;
              m_fs = sr ? j : -1;
            end else if (j - m_c0 == MAXV) begin
              e_err = 1'b1; e_lock = 1'b0; m_match = 0; m_have_prev = 1'b0;
              m_mode = 1;
            end else if (sr && m_fs < 0) begin
              m_fs = j;
            end
          end
        end
      end
    end
  end

  // ---------------- per-cycle compare + event monitor ----------------
  int ncyc = 0;
  int vcount = 0, ecount = 0;
  int last_valid_cyc = 0, last_err_cyc = 0;
  bit last_valid_lock = 1'b0;

  initial begin : compare
    logic [26:0] actv, expv;
    forever begin
      @(negedge clk);
      ncyc++;
      actv = {period_cnt, offset_cnt, high_cnt, valid, lock, err};
      if (RST) expv = '0;
      else     expv = {W'(e_period), W'(e_offset), W'(e_high), e_valid, e_lock, e_err};
      check($sformatf("cycle%0d {period,offset,high,valid,lock,err}", ncyc), 32'(actv), 32'(expv));
      if (valid) begin
        vcount++;
        last_valid_cyc  = ncyc;
        last_valid_lock = lock;
      end
      if (err) begin
        ecount++;
        last_err_cyc = ncyc;
      end
    end
  end

  // ---------------- directed sequence with literal expectations ----------------
  task automatic wait_phase(input int p);
    @(posedge clk); #2;
    while (t % P != p) begin
      @(posedge clk); #2;
    end
  endtask

  task automatic wait_valid(input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk); #1;
      seen = valid;
    end
    check("valid_within_budget", 32'(seen), 32'd1);
  endtask

  task automatic wait_err(input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk); #1;
      seen = err;
    end
    check("err_within_budget", 32'(seen), 32'd1);
  endtask

  initial begin : main
    int ne, nv, nl;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    check("reset_outputs", 32'({period_cnt, offset_cnt, high_cnt, valid, lock, err}), 32'd0);
    wait_phase(17);
    RST = 1'b0;

    // 90 degrees, 50% duty
    wait_valid(80);
    check("deg90_period", 32'(period_cnt), 32'd20);
    check("deg90_offset", 32'(offset_cnt), 32'd5);
    check("deg90_high", 32'(high_cnt), 32'd10);
    check("deg90_lock_v1", 32'(lock), 32'd0);
    for (int k = 2; k <= 4; k++) begin
      wait_valid(40);
      check($sformatf("deg90_lock_v%0d", k), 32'(lock), (k == 4) ? 32'd1 : 32'd0);
    end

    // offset jump 5 -> 8 while locked
    wait_phase(0);
    off = 8;
    wait_valid(40);
    wait_valid(40);
    check("jump_offset", 32'(offset_cnt), 32'd8);
    check("jump_lock", 32'(lock), 32'd0);
    for (int k = 1; k <= 3; k++) begin
      wait_valid(40);
      check($sformatf("relock_v%0d", k), 32'(lock), (k == 3) ? 32'd1 : 32'd0);
    end

    // power-down mid-window
    wait_phase(7);
    PWRDWN = 1'b1;
    @(posedge clk);
    @(negedge clk); #1;
    check("pwrdwn_outputs", 32'({period_cnt, offset_cnt, high_cnt, valid, lock, err}), 32'd0);
    repeat (2) @(posedge clk);
    #2;
    PWRDWN = 1'b0;
    wait_valid(80);
    check("after_pwrdwn_period", 32'(period_cnt), 32'd20);
    check("after_pwrdwn_offset", 32'(offset_cnt), 32'd8);

    // 0 degrees
    wait_phase(0);
    off = 0;
    repeat (3) wait_valid(40);
    check("deg0_offset", 32'(offset_cnt), 32'd0);
    check("deg0_period", 32'(period_cnt), 32'd20);
    check("deg0_high", 32'(high_cnt), 32'd10);

    // 270 degrees, 25% duty (sig falls on the ref rise)
    wait_phase(0);
    off = 15;
    hi  = 5;
    repeat (3) wait_valid(40);
    check("deg270_offset", 32'(offset_cnt), 32'd15);
    check("deg270_high", 32'(high_cnt), 32'd5);
    check("deg270_period", 32'(period_cnt), 32'd20);

    // sig stuck low
    wait_phase(0);
    sig_run = 1'b0;
    wait_err(60);
    ne = 0; nv = 0; nl = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk); #1;
      ne += int'(err);
      nv += int'(valid);
      nl += int'(lock);
    end
    check("stuck_err_count", 32'(ne), 32'd4);
    check("stuck_valid_count", 32'(nv), 32'd0);
    check("stuck_lock_cycles", 32'(nl), 32'd0);

    // relock at 90 degrees, then stop ref to force counter overflow
    wait_phase(0);
    off = 5; hi = 10; sig_run = 1'b1;
    repeat (5) wait_valid(40);
    check("relock_before_stop", 32'(lock), 32'd1);
    wait_phase(0);
    ref_run = 1'b0;
    wait_err(300);
    check("overflow_gap", 32'(last_err_cyc - last_valid_cyc), 32'd255);
    check("overflow_lock_before", 32'(last_valid_lock), 32'd1);
    check("overflow_lock_after", 32'(lock), 32'd0);
    wait_phase(0);
    ref_run = 1'b1;
    wait_valid(80);
    check("resume_period", 32'(period_cnt), 32'd20);
    check("resume_offset", 32'(offset_cnt), 32'd5);

    // asynchronous reset mid-window
    wait_phase(10);
    @(posedge clk); #3;
    RST = 1'b1;
    #1;
    check("rst_async_outputs", 32'({period_cnt, offset_cnt, high_cnt, valid, lock, err}), 32'd0);
    wait_phase(17);
    RST = 1'b0;
    wait_valid(80);
    check("after_rst_period", 32'(period_cnt), 32'd20);
    check("after_rst_offset", 32'(offset_cnt), 32'd5);
    check("after_rst_high", 32'(high_cnt), 32'd10);
    check("after_rst_lock", 32'(lock), 32'd0);

    repeat (5) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got no finish expected finish before 2 ms");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/phase_measure.md
PHASE_MEASURE -- requirements
Module: phase_measure

Interface
REQ-001 SHALL: parameter CNT_W, 16, counter/result width in clk cycles.
REQ-002 SHALL: parameter LOCK_COUNT, 4, consecutive matching windows required for lock.
REQ-003 SHALL: parameter TOL, 1, allowed +/- cycle deviation between consecutive windows.
REQ-004 SHALL: one clock; reset asynchronous and active-high: clk  in  1  sampling clock; RST  in  1  async active-high reset.
REQ-005 SHALL: PWRDWN  in  1  synchronous power-down, active-high.
REQ-006 SHALL: ref_in  in  1  reference clock, asynchronous to clk.
REQ-007 SHALL: sig_in  in  1  shifted clock under measurement, asynchronous to clk.
REQ-008 SHALL: period_cnt  out  CNT_W  ref period in clk cycles.
REQ-009 SHALL: offset_cnt  out  CNT_W  ref-rise to first sig-rise delay in clk cycles.
REQ-010 SHALL: high_cnt  out  CNT_W  last completed sig high time in clk cycles.
REQ-011 SHALL: valid  out  1  one-cycle pulse when results update.
REQ-012 SHALL: lock  out  1  level, stable measurement; err  out  1  one-cycle error pulse.

Function
REQ-013 SHALL: ref_in and sig_in each pass a 2-flop synchronizer; rise/fall detected by comparing synchronized value to a third registered copy (3-cycle input latency, identical for both paths).
REQ-014 SHALL: FSM states IDLE, WAIT_REF, MEAS; RST or PWRDWN -> IDLE; IDLE -> WAIT_REF when PWRDWN=0; WAIT_REF -> MEAS on ref rise.
REQ-015 SHALL: window start = cycle of ref rise c0; elapsed e = c - c0 for each later cycle c.
REQ-016 SHALL: offset = e at first sig rise in window; sig rise in cycle c0 gives offset 0; further sig rises in same window ignored.
REQ-017 SHALL: independent high counter counts sig rise to sig fall (fall cycle minus rise cycle); value latched as high_last on each fall; may span windows.
REQ-018 SHALL: on next ref rise in MEAS: if a sig rise occurred in window, period_cnt<=e, offset_cnt<=offset, high_cnt<=high_last, valid=1 for that cycle; same cycle starts new window (stay MEAS).
REQ-019 SHALL: window closing with no sig rise -> err=1 one cycle, no valid, outputs held, lock cleared, new window starts.
REQ-020 SHALL: e reaching 2^CNT_W-1 without ref rise -> err=1 one cycle, lock cleared, FSM -> WAIT_REF; high counter saturates at 2^CNT_W-1.
REQ-021 SHALL: match counter increments on each valid whose period and offset both differ from previous valid values by <= TOL; any mismatch or err resets it to 0.
REQ-022 SHALL: lock=1 when match counter >= LOCK_COUNT-1 (i.e. LOCK_COUNT consecutive consistent windows incl. first), 0 otherwise; deasserted in the cycle of mismatch/err.
REQ-023 SHALL: first valid occurs at the second ref rise after entering WAIT_REF.
REQ-024 SHALL: PWRDWN=1 -> next cycle all outputs 0, FSM IDLE, counters cleared; release resumes via WAIT_REF.

Reset
REQ-025 SHALL: RST=1 asynchronously clears period_cnt, offset_cnt, high_cnt, valid, lock, err, match counter, synchronizers to 0, FSM to IDLE.
REQ-026 SHALL: RST mid-window discards partial measurement; no valid until two ref rises after release.

Verification
REQ-027 SHALL: clk 10 ns, ref 200 ns, sig shifted 90 deg 50% duty -> period_cnt=20, offset_cnt=5, high_cnt=10; lock=1 at 4th valid.
REQ-028 SHALL: sig equal to ref (0 deg) -> offset_cnt=0, period_cnt=20; sig shifted 270 deg, 25% duty -> offset_cnt=15, high_cnt=5.
REQ-029 SHALL: sig stuck 0 with ref running -> err pulse every 20 cycles, valid never, lock=0.
REQ-030 SHALL: CNT_W=8, ref stuck after start -> err pulse 255 cycles after last ref rise, lock 1->0, FSM WAIT_REF.
REQ-031 SHALL: locked stream, offset jumps 5->8 cycles -> lock=0 on that valid; relock after 3 more matching valids.
REQ-032 SHALL: RST or PWRDWN pulse mid-window -> all outputs 0 next edge (RST immediately); first valid at 2nd ref rise after release.
